spi_frame_tx: RTL and testbench

//  SPI mode-0 controller, MSB-first, byte-granular: drives CS/SCK/MOSI to stream framed byte bursts

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 33 +++
 rtl/spi_frame_tx.sv | 143 ++++++++++++++
 tb/tb_spi_frame_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame transmitter: FSM states and
// mode-0 framing constants.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LOW  = 3'd2,
    HIGH = 3'd3,
    HOLD = 3'd4,
    GAP  = 3'd5
  } state_t;

  localparam int   SPI_BYTE_W = 8;
  localparam logic CPOL       = 1'b0;  // SCK idles low
  localparam logic CPHA       = 1'b0;  // data sampled on the leading (rising) edge

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for SCK: counts CLK_DIV clk cycles while enabled and
// flags the last one with 'tick'. Cleared when a new byte is loaded so every
// byte starts with a full low half-period.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TC    = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TC);

  // Half-period counter, wraps to 0 on terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TC) cnt <= '0;
      else           cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter, MSB first. Accepts bytes on a valid/ready
// stream and sends frame_len of them inside one CS-low frame, with a CS hold
// time after the last SCK fall and a minimum CS-high gap between frames.
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_HOLD = 2,
  parameter int CS_IDLE = 2,
  parameter int LEN_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             CS,
  output logic             SCK,
  output logic             MOSI
);

  localparam int DLY_MAX = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int DLY_W   = (DLY_MAX > 0) ? $clog2(DLY_MAX + 1) : 1;
  localparam int BIT_W   = $clog2(SPI_BYTE_W);

  state_t                  state;
  logic [LEN_W-1:0]        remaining;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SPI_BYTE_W-1:0]   shreg;
  logic [DLY_W-1:0]        dly_cnt;
  logic                    tick;
  logic                    hp_en;

  // A byte is only ever taken in LOAD, so ready is a pure state decode
  assign tx_ready = (state == LOAD);
  assign hp_en    = (state == LOW) || (state == HIGH);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hp_en),
    .clr   (tx_ready && tx_valid),
    .tick  (tick)
  );

  // Frame sequencer: CS framing, SCK generation, shift-out and byte counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      CS        <= 1'b1;
      SCK       <= CPOL;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dly_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              CS        <= 1'b0;
              remaining <= frame_len;
              busy      <= 1'b1;
              state     <= LOAD;
            end else begin
              // Empty frame: acknowledge without touching the bus
              done <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (tx_valid) begin
            shreg   <= tx_data;
            MOSI    <= tx_data[SPI_BYTE_W-1];
            bit_cnt <= BIT_W'(SPI_BYTE_W - 1);
            state   <= LOW;
          end
        end

        LOW: begin
          if (tick) begin
            SCK   <= ~CPOL;
            state <= HIGH;
          end
        end

        HIGH: begin
          if (tick) begin
            SCK <= CPOL;
            if (bit_cnt != '0) begin
              shreg   <= {shreg[SPI_BYTE_W-2:0], 1'b0};
              MOSI    <= shreg[SPI_BYTE_W-2];
              bit_cnt <= bit_cnt - BIT_W'(1);
              state   <= LOW;
            end else begin
              remaining <= remaining - LEN_W'(1);
              dly_cnt   <= '0;
              state     <= (remaining == LEN_W'(1)) ? HOLD : LOAD;
            end
          end
        end

        HOLD: begin
          if (dly_cnt == DLY_W'(CS_HOLD - 1)) begin
            CS      <= 1'b1;
            done    <= 1'b1;
            MOSI    <= 1'b0;
            dly_cnt <= '0;
            state   <= GAP;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end

        GAP: begin
          // CS stays high for CS_IDLE full cycles after the done cycle
          if (dly_cnt == DLY_W'(CS_IDLE)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx (CLK_DIV=4, CS_HOLD=2, CS_IDLE=2): a bus
// monitor decodes the SPI pins back into bytes and expected values are
// hand-derived from the frame timing.
`timescale 1ns/1ps
module tb_spi_frame_tx;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [7:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready, busy, done, CS, SCK, MOSI;

  int n_chk = 0;
  int n_pass = 0;

  // Bus monitor state
  int         rise_total = 0;
  int         done_total = 0;
  int         sck_bad = 0;
  int         rx_bits = 0;
  int         cs_run = 0;
  int         gap_min = 1000;
  bit         seen_low = 0;
  logic       sck_prev = 1'b0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  logic [7:0] src_q[$];

  // Per-cycle capture for the timing test
  logic cs_h[0:79], sck_h[0:79], done_h[0:79], busy_h[0:79];

  spi_frame_tx #(
    .CLK_DIV (4),
    .CS_HOLD (2),
    .CS_IDLE (2),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .CS        (CS),
    .SCK       (SCK),
    .MOSI      (MOSI)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // SPI receiver model: samples MOSI on SCK rise while CS low, clears on CS high
  always @(negedge clk) begin
    if (done === 1'b1) done_total++;
    if (CS !== 1'b0) begin
      rx_bits = 0;
      if (SCK === 1'b1 && sck_prev === 1'b0) sck_bad++;
      cs_run++;
    end else begin
      if (seen_low && cs_run > 0 && cs_run < gap_min) gap_min = cs_run;
      seen_low = 1;
      cs_run = 0;
      if (SCK === 1'b1 && sck_prev === 1'b0) begin
        rise_total++;
        rx_sh = {rx_sh[6:0], MOSI};
        rx_bits++;
        if (rx_bits == 8) begin
          rx_q.push_back(rx_sh);
          rx_bits = 0;
        end
      end
    end
    sck_prev = SCK;
  end

  // Runs one frame from src_q; optional random valid gaps and a stall before byte 1
  task automatic run_frame(input string tag, input int len, input bit rnd,
                           input int stall_len, output int rises);
    int  idx, guard, limit, stall_cnt, stall_bad, r0, d0, nbad;
    bit  hs, finished, stall_on;
    idx = 0; stall_cnt = 0; stall_bad = 0; stall_on = 0; finished = 0; guard = 0;
    limit = len * 80 + 200;
    r0 = rise_total; d0 = done_total;
    rx_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = LEN_W'(len);
    while (!finished && guard < limit) begin
      if (idx < len && !(idx == 1 && stall_len > 0 && stall_cnt < stall_len))
        tx_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      else
        tx_valid = 1'b0;
      tx_data = (idx < len) ? src_q[idx] : 8'h00;
      @(negedge clk);
      hs = tx_valid && tx_ready;
      if (idx == 1 && stall_len > 0 && stall_cnt < stall_len && (tx_ready === 1'b1 || stall_on)) begin
        stall_on = 1;
        stall_cnt++;
        if (tx_ready !== 1'b1 || SCK !== 1'b0 || CS !== 1'b0) stall_bad++;
      end
      if (done === 1'b1) finished = 1;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      guard++;
    end
    tx_valid = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    rises = rise_total - r0;
    check_val({tag, ".finished"}, 32'(finished), 32'd1);
    check_val({tag, ".idle"}, 32'(busy), 32'd0);
    check_val({tag, ".done_cnt"}, 32'(done_total - d0), 32'd1);
    check_val({tag, ".rx_cnt"}, 32'(rx_q.size()), 32'(len));
    nbad = 0;
    for (int i = 0; i < len; i++)
      if (i >= rx_q.size() || rx_q[i] !== src_q[i]) nbad++;
    check_val({tag, ".data_bad"}, 32'(nbad), 32'd0);
    if (stall_len > 0) begin
      check_val({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(stall_len));
      check_val({tag, ".stall_bus"}, 32'(stall_bad), 32'd0);
    end
  endtask

  initial begin
    int rises, r0, d0, guard, sck_err, len;
    logic exp_sck;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.CS", 32'(CS), 32'd1);
    check_val("rst.SCK", 32'(SCK), 32'd0);
    check_val("rst.MOSI", 32'(MOSI), 32'd0);
    check_val("rst.tx_ready", 32'(tx_ready), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ---------------- test 1: single byte, exact timing ----------------
    rx_q.delete();
    r0 = rise_total;
    @(posedge clk); #1;
    start = 1'b1; frame_len = LEN_W'(1); tx_data = 8'hA5; tx_valid = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 2) tx_valid = 1'b0;
      cs_h[c] = CS; sck_h[c] = SCK; done_h[c] = done; busy_h[c] = busy;
    end
    check_val("t1.cs_low_first", 32'(cs_h[1]), 32'd0);
    check_val("t1.cs_low_last", 32'(cs_h[67]), 32'd0);
    check_val("t1.cs_rise", 32'(cs_h[68]), 32'd1);
    check_val("t1.done_early", 32'(done_h[67]), 32'd0);
    check_val("t1.done", 32'(done_h[68]), 32'd1);
    check_val("t1.done_width", 32'(done_h[69]), 32'd0);
    check_val("t1.busy_gap", 32'(busy_h[70]), 32'd1);
    check_val("t1.busy_off", 32'(busy_h[71]), 32'd0);
    sck_err = 0;
    for (int c = 1; c <= 75; c++) begin
      exp_sck = (c >= 6 && c <= 65 && ((c - 6) % 8) < 4);
      if (sck_h[c] !== exp_sck) sck_err++;
    end
    check_val("t1.sck_wave", 32'(sck_err), 32'd0);
    check_val("t1.rises", 32'(rise_total - r0), 32'd8);
    check_val("t1.rx_cnt", 32'(rx_q.size()), 32'd1);
    check_val("t1.rx_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF, 32'hA5);

    // ---------------- test 2: three bytes back-to-back ----------------
    src_q = '{8'h00, 8'hFF, 8'h3C};
    run_frame("t2", 3, 1'b0, 0, rises);
    check_val("t2.rises", 32'(rises), 32'd24);

    // ---------------- test 3: stall before byte 1 ----------------
    src_q = '{8'h81, 8'h7E};
    run_frame("t3", 2, 1'b0, 20, rises);
    check_val("t3.rises", 32'(rises), 32'd16);

    // ---------------- test 4: reset mid-byte ----------------
    rx_q.delete();
    r0 = rise_total; d0 = done_total;
    @(posedge clk); #1;
    start = 1'b1; frame_len = LEN_W'(1); tx_data = 8'h77; tx_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    guard = 0;
    while (rise_total - r0 < 4 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    check_val("t4.reach_rise4", 32'(guard < 200), 32'd1);
    check_val("t4.sck_before", 32'(SCK), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("t4.CS", 32'(CS), 32'd1);
    check_val("t4.SCK", 32'(SCK), 32'd0);
    check_val("t4.MOSI", 32'(MOSI), 32'd0);
    check_val("t4.busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("t4.no_done", 32'(done_total - d0), 32'd0);
    check_val("t4.no_byte", 32'(rx_q.size()), 32'd0);
    src_q = '{8'h5A};
    run_frame("t4b", 1, 1'b0, 0, rises);

    // ---------------- test 5: start ignored while busy; empty frame ----------------
    rx_q.delete();
    d0 = done_total;
    @(posedge clk); #1;
    start = 1'b1; frame_len = LEN_W'(1); tx_data = 8'hC3; tx_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (SCK !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    tx_valid = 1'b0;
    check_val("t5.reach_high", 32'(guard < 100), 32'd1);
    start = 1'b1; frame_len = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("t5.reach_done", 32'(guard < 200), 32'd1);
    start = 1'b1; frame_len = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("t5.busy", 32'(busy), 32'd0);
    check_val("t5.CS", 32'(CS), 32'd1);
    check_val("t5.rx_cnt", 32'(rx_q.size()), 32'd1);
    check_val("t5.rx_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF, 32'hC3);
    check_val("t5.done_cnt", 32'(done_total - d0), 32'd1);
    start = 1'b1; frame_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t5.len0_done", 32'(done), 32'd1);
    check_val("t5.len0_CS", 32'(CS), 32'd1);
    check_val("t5.len0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_val("t5.len0_pulse", 32'(done), 32'd0);
    check_val("t5.len0_CS2", 32'(CS), 32'd1);

    // ---------------- test 6: random lengths and valid gaps ----------------
    gap_min = 1000;
    for (int f = 0; f < 2; f++) begin
      len = (f == 0) ? $urandom_range(1, 40) : $urandom_range(300, 640);
      src_q.delete();
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom_range(0, 255)));
      run_frame((f == 0) ? "t6a" : "t6b", len, 1'b1, 0, rises);
      check_val((f == 0) ? "t6a.rises" : "t6b.rises", 32'(rises), 32'(8 * len));
    end
    check_val("t6.cs_gap_ok", 32'(gap_min >= 2), 32'd1);
    check_val("all.sck_while_cs_high", 32'(sck_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
